a5_keystream_gen: RTL and testbench
===================================

// Module: a5_keystream_gen
// PURPOSE
//  Complete A5/1-style keystream generator built from three parametrised LFSRs with majority clocking.
//  Sequences session setup itself: key load, frame load, mix phase, then keystream delivery.
//  Keystream leaves one bit per beat over a valid/ready handshake to the wishbone-facing cipher datapath.
//  Register geometry is generic, so variant ciphers reuse the block by overriding parameters.
// PARAMETERS
//  KEY_BITS     64        key length; one key bit absorbed per load cycle
//  FRAME_BITS   22        frame-number length; one bit per load cycle
//  MIX_CYCLES   101       majority clocks before the first presented bit (100 discarded + 1)
//  STREAM_BITS  228       keystream beats per session
//  Rn_BITS      19/22/23  width of R1/R2/R3
//  Rn_TAPS      'h72000/'h300000/'h700080  feedback tap masks (XOR of sr[i] where mask[i]=1)
//  Rn_CLKBIT    8/10/10   clocking-bit index per register
// PORTS
//  clk        in   1           clock
//  reset_n    in   1           asynchronous, active-low reset
//  start      in   1           begin a session; sampled only in IDLE
//  abort      in   1           synchronous return to IDLE from any state
//  key        in   KEY_BITS    key; bit i absorbed on load cycle i; held stable while busy
//  frame      in   FRAME_BITS  frame number; bit i absorbed on frame cycle i; held stable while busy
//  ks_bit     out  1           keystream bit: XOR of the three register MSBs
//  ks_valid   out  1           ks_bit valid
//  ks_ready   in   1           consumer accepts ks_bit
//  busy       out  1           high in every state except IDLE
//  done       out  1           one-cycle pulse after the final beat is accepted
// BEHAVIOUR
//  Reset: all registers zero, FSM=IDLE, ks_bit=0, ks_valid=0, busy=0, done=0, counters zero.
//  Register step: sr <= {sr[N-2:0], d ^ fb}; fb = ^(sr & Rn_TAPS); MSB is the register output.
//  FSM: IDLE -> KEY -> FRAME -> MIX -> STREAM -> IDLE. One shared counter cnt is cleared on each transition.
//   IDLE:   start=1 -> zero all three registers, cnt=0, go to KEY. busy rises the next cycle.
//   KEY:    all registers step every cycle with d=key[cnt]. After KEY_BITS cycles go to FRAME.
//   FRAME:  all registers step with d=frame[cnt]. After FRAME_BITS cycles go to MIX.
//   MIX:    majority clocking with d=0. After MIX_CYCLES cycles go to STREAM.
//   STREAM: ks_valid=1 and ks_bit=XOR of the MSBs. No register moves until ks_valid&&ks_ready.
//           On an accepted beat: majority step, cnt++.
//           Accepting beat STREAM_BITS-1 -> IDLE, ks_valid=0 next cycle, done=1 for one cycle.
//  Majority step: m = maj(R1[C1],R2[C2],R3[C3]); register n steps iff Rn[Cn]==m.
//   At least two registers step on every majority step.
//  ks_bit/ks_valid are registered; ks_bit must not change while ks_valid=1 and ks_ready=0.
//  Latency: start high in IDLE -> first ks_valid = KEY_BITS+FRAME_BITS+MIX_CYCLES+1 cycles later
//   (188 at defaults).
//  Handshake: ks_ready is a don't-care while ks_valid=0. ks_ready held high -> one beat per cycle.
//  start while busy: ignored. start on the same cycle as done: ignored; done is not a re-arm.
//  abort: highest priority. Next cycle FSM=IDLE, ks_valid=0, busy=0.
//   done is not pulsed. Register contents are don't-care until the next start re-zeros them.
//  reset_n low mid-session: immediate return to the reset state, no done pulse.
//  Counter width: $clog2 of the largest of KEY_BITS, FRAME_BITS, MIX_CYCLES, STREAM_BITS, plus 1.
// TESTING
//  1 Known answer: key bytes 12 23 45 67 89 AB CD EF (key=64'hEFCDAB8967452312, byte0 LSB-first),
//    frame=22'h134, ks_ready=1 -> beats 0..113 packed MSB-first = 534EAA582FE8151AB6E1855A728C00.
//    Beats 114..227 = 24FD35A35D5FB6526D32F906DF1AC0.
//  2 Backpressure: same vector, ks_ready randomly toggled -> identical 228-bit stream;
//    ks_bit stable during every stall; exactly one done pulse.
//  3 Latency/timing: start pulse -> busy=1 one cycle later, first ks_valid 188 cycles after start;
//    done 1 cycle after beat 227; second start mid-STREAM has no effect.
//  4 Abort: abort at MIX cycle 50 -> IDLE next cycle with no done pulse;
//    a fresh start then reproduces test 1's stream exactly.
//  5 Reset: reset_n low during STREAM beat 40 -> every output 0 immediately;
//    after release, start reproduces test 1.
//  6 Majority property: over a full session, assert >=2 registers step on every MIX/accepted STREAM cycle.
//    Zero key + zero frame -> stream is all zeros.

Source files
------------

// File: rtl/a5_keystream_gen.sv
// a5_keystream_gen: A5/1-style keystream generator. Three LFSRs absorb the
// key and frame number, are majority-clocked through a mix phase, then emit
// one keystream bit per accepted valid/ready beat.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | waiting for start; registers hold last contents
// S_KEY    | all registers step, absorbing key[cnt]
// S_FRAME  | all registers step, absorbing frame[cnt]
// S_MIX    | majority clocking with zero input, output discarded
// S_STREAM | ks_valid high; majority step on every accepted beat
module a5_keystream_gen #(
    parameter int          KEY_BITS    = 64,
    parameter int          FRAME_BITS  = 22,
    parameter int          MIX_CYCLES  = 101,
    parameter int          STREAM_BITS = 228,
    parameter int          R1_BITS     = 19,
    parameter int          R2_BITS     = 22,
    parameter int          R3_BITS     = 23,
    parameter logic [63:0] R1_TAPS     = 64'h0000_0000_0007_2000,
    parameter logic [63:0] R2_TAPS     = 64'h0000_0000_0030_0000,
    parameter logic [63:0] R3_TAPS     = 64'h0000_0000_0070_0080,
    parameter int          R1_CLKBIT   = 8,
    parameter int          R2_CLKBIT   = 10,
    parameter int          R3_CLKBIT   = 10
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [KEY_BITS-1:0]   key,
    input  logic [FRAME_BITS-1:0] frame,
    output logic                  ks_bit,
    output logic                  ks_valid,
    input  logic                  ks_ready,
    output logic                  busy,
    output logic                  done
);

    localparam int MAX_KF   = (KEY_BITS > FRAME_BITS) ? KEY_BITS : FRAME_BITS;
    localparam int MAX_MS   = (MIX_CYCLES > STREAM_BITS) ? MIX_CYCLES : STREAM_BITS;
    localparam int MAX_LEN  = (MAX_KF > MAX_MS) ? MAX_KF : MAX_MS;
    localparam int CNT_W    = $clog2(MAX_LEN) + 1;
    localparam int KEY_IW   = (KEY_BITS > 1) ? $clog2(KEY_BITS) : 1;
    localparam int FRAME_IW = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;

    localparam logic [CNT_W-1:0] KEY_LAST    = CNT_W'(KEY_BITS - 1);
    localparam logic [CNT_W-1:0] FRAME_LAST  = CNT_W'(FRAME_BITS - 1);
    localparam logic [CNT_W-1:0] MIX_LAST    = CNT_W'(MIX_CYCLES - 1);
    localparam logic [CNT_W-1:0] STREAM_LAST = CNT_W'(STREAM_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_KEY,
        S_FRAME,
        S_MIX,
        S_STREAM
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [R1_BITS-1:0] r1;
    logic [R2_BITS-1:0] r2;
    logic [R3_BITS-1:0] r3;
    logic [R1_BITS-1:0] r1_nxt;
    logic [R2_BITS-1:0] r2_nxt;
    logic [R3_BITS-1:0] r3_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [2:0]         step_en;
    logic               maj;
    logic               d_bit;
    logic               accept;
    logic               last;
    logic               ks_nxt;

    assign busy = (state != S_IDLE);

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Input bit, per-register step enables and the candidate register values.
    always_comb begin
        d_bit   = 1'b0;
        step_en = 3'b000;
        last    = 1'b0;
        maj     = (r1[R1_CLKBIT] & r2[R2_CLKBIT]) |
                  (r1[R1_CLKBIT] & r3[R3_CLKBIT]) |
                  (r2[R2_CLKBIT] & r3[R3_CLKBIT]);
        accept  = (state == S_STREAM) && ks_valid && ks_ready;
        unique case (state)
            S_KEY: begin
                d_bit   = key[cnt[KEY_IW-1:0]];
                step_en = 3'b111;
                last    = (cnt == KEY_LAST);
            end
            S_FRAME: begin
                d_bit   = frame[cnt[FRAME_IW-1:0]];
                step_en = 3'b111;
                last    = (cnt == FRAME_LAST);
            end
            S_MIX: begin
                step_en = {r3[R3_CLKBIT] == maj, r2[R2_CLKBIT] == maj, r1[R1_CLKBIT] == maj};
                last    = (cnt == MIX_LAST);
            end
            S_STREAM: begin
                if (accept) begin
                    step_en = {r3[R3_CLKBIT] == maj, r2[R2_CLKBIT] == maj, r1[R1_CLKBIT] == maj};
                end
                last = (cnt == STREAM_LAST);
            end
            default: ;
        endcase
        r1_nxt = step_en[0] ? {r1[R1_BITS-2:0], d_bit ^ (^(r1 & R1_TAPS[R1_BITS-1:0]))} : r1;
        r2_nxt = step_en[1] ? {r2[R2_BITS-2:0], d_bit ^ (^(r2 & R2_TAPS[R2_BITS-1:0]))} : r2;
        r3_nxt = step_en[2] ? {r3[R3_BITS-2:0], d_bit ^ (^(r3 & R3_TAPS[R3_BITS-1:0]))} : r3;
        ks_nxt = r1_nxt[R1_BITS-1] ^ r2_nxt[R2_BITS-1] ^ r3_nxt[R3_BITS-1];
    end

    // Phase sequencing; abort overrides everything. A start coinciding with
    // the done pulse is ignored so done can never re-arm a session.
    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = S_IDLE;
        end else begin
            unique case (state)
                S_IDLE:   if (start && !done) state_nxt = S_KEY;
                S_KEY:    if (last) state_nxt = S_FRAME;
                S_FRAME:  if (last) state_nxt = S_MIX;
                S_MIX:    if (last) state_nxt = S_STREAM;
                S_STREAM: if (accept && last) state_nxt = S_IDLE;
                default:  state_nxt = S_IDLE;
            endcase
        end
    end

    // Registers, phase counter and registered keystream outputs. ks_bit only
    // moves on an accepted beat, so it is stable through stalls.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r1       <= '0;
            r2       <= '0;
            r3       <= '0;
            cnt      <= '0;
            ks_bit   <= 1'b0;
            ks_valid <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                cnt      <= '0;
                ks_bit   <= 1'b0;
                ks_valid <= 1'b0;
            end else begin
                unique case (state)
                    S_IDLE: begin
                        if (start && !done) begin
                            r1  <= '0;
                            r2  <= '0;
                            r3  <= '0;
                            cnt <= '0;
                        end
                    end
                    S_KEY, S_FRAME: begin
                        r1  <= r1_nxt;
                        r2  <= r2_nxt;
                        r3  <= r3_nxt;
                        cnt <= last ? '0 : cnt + CNT_W'(1);
                    end
                    S_MIX: begin
                        r1 <= r1_nxt;
                        r2 <= r2_nxt;
                        r3 <= r3_nxt;
                        if (last) begin
                            cnt      <= '0;
                            ks_valid <= 1'b1;
                            ks_bit   <= ks_nxt;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    S_STREAM: begin
                        if (accept) begin
                            r1 <= r1_nxt;
                            r2 <= r2_nxt;
                            r3 <= r3_nxt;
                            if (last) begin
                                cnt      <= '0;
                                ks_valid <= 1'b0;
                                ks_bit   <= 1'b0;
                                done     <= 1'b1;
                            end else begin
                                cnt    <= cnt + CNT_W'(1);
                                ks_bit <= ks_nxt;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_a5_keystream_gen.sv
// tb_a5_keystream_gen: directed sessions plus randomized key/frame/backpressure
// runs, checked against a bit-array model of the A5/1 generator.
module tb_a5_keystream_gen;

    localparam logic [63:0] KAT_KEY   = 64'hEFCDAB8967452312;
    localparam logic [21:0] KAT_FRAME = 22'h134;

    logic        clk      = 1'b0;
    logic        reset_n  = 1'b0;
    logic        start    = 1'b0;
    logic        abort    = 1'b0;
    logic        ks_ready = 1'b0;
    logic [63:0] key      = '0;
    logic [21:0] frame    = '0;
    logic        ks_bit;
    logic        ks_valid;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    logic [227:0] got;
    logic [227:0] kat_exp;
    logic [227:0] model_bits;
    logic [119:0] ka;
    logic [119:0] kb;

    int done_cnt  = 0;
    int stall_err = 0;
    int maj_err   = 0;
    int maj_two   = 0;
    logic stalled  = 1'b0;
    logic held_bit = 1'b0;

    // reference model state: one bit array per register, taps as index lists
    bit mr [3][23];
    int reg_len [3]     = '{19, 22, 23};
    int clk_pos [3]     = '{8, 10, 10};
    int tap_idx [3][4]  = '{'{13, 16, 17, 18}, '{20, 21, -1, -1}, '{7, 20, 21, 22}};

    a5_keystream_gen dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .abort    (abort),
        .key      (key),
        .frame    (frame),
        .ks_bit   (ks_bit),
        .ks_valid (ks_valid),
        .ks_ready (ks_ready),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    // done pulse counter
    always @(negedge clk) begin
        if (done === 1'b1) done_cnt++;
    end

    // ks_bit must hold across a stalled beat
    always @(posedge clk) begin
        stalled  <= ks_valid && !ks_ready && reset_n && !abort;
        held_bit <= ks_bit;
    end
    always @(negedge clk) begin
        if (stalled && ks_valid && (ks_bit !== held_bit)) stall_err++;
    end

    // every majority step moves at least two registers
    always @(negedge clk) begin
        if (dut.step_en != 3'b000 && $countones(dut.step_en) < 2) maj_err++;
        if ($countones(dut.step_en) == 2) maj_two++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic check_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_vec(input string tag, input logic [227:0] obs, input logic [227:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit fb_of(input int n);
        bit x;
        x = 1'b0;
        for (int t = 0; t < 4; t++) begin
            if (tap_idx[n][t] >= 0) x ^= mr[n][tap_idx[n][t]];
        end
        return x;
    endfunction

    function automatic void shift_in(input int n, input bit d);
        bit nb;
        nb = fb_of(n) ^ d;
        for (int i = reg_len[n] - 1; i > 0; i--) mr[n][i] = mr[n][i-1];
        mr[n][0] = nb;
    endfunction

    function automatic void maj_step();
        bit c [3];
        int ones;
        bit m;
        ones = 0;
        for (int n = 0; n < 3; n++) begin
            c[n] = mr[n][clk_pos[n]];
            ones += int'(c[n]);
        end
        m = (ones >= 2);
        for (int n = 0; n < 3; n++) begin
            if (c[n] == m) shift_in(n, 1'b0);
        end
    endfunction

    function automatic bit out_bit();
        return mr[0][reg_len[0]-1] ^ mr[1][reg_len[1]-1] ^ mr[2][reg_len[2]-1];
    endfunction

    task automatic build_ref(input logic [63:0] k, input logic [21:0] f);
        for (int n = 0; n < 3; n++)
            for (int i = 0; i < 23; i++) mr[n][i] = 1'b0;
        for (int i = 0; i < 64; i++)
            for (int n = 0; n < 3; n++) shift_in(n, k[i]);
        for (int i = 0; i < 22; i++)
            for (int n = 0; n < 3; n++) shift_in(n, f[i]);
        for (int i = 0; i < 101; i++) maj_step();
        for (int i = 0; i < 228; i++) begin
            model_bits[i] = out_bit();
            maj_step();
        end
    endtask

    // One session from start. abort_cyc/reset_beat >= 0 cut it short.
    task automatic run_session(input logic [63:0] k, input logic [21:0] f, input bit rnd,
                               input bit mid_start, input bit done_start,
                               input int abort_cyc, input int reset_beat, input string tag);
        int cyc;
        int beats;
        int first;
        int done0;
        got   = '0;
        beats = 0;
        first = -1;
        done0 = done_cnt;
        @(negedge clk);
        key      = k;
        frame    = f;
        start    = 1'b1;
        ks_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc   = 1;
        check_int({tag, "_busy_rise"}, int'(busy), 1);
        while (beats < 228 && cyc < 5000) begin
            if (cyc == abort_cyc) begin
                abort = 1'b1;
                @(negedge clk);
                abort = 1'b0;
                check_int({tag, "_abort_busy"}, int'(busy), 0);
                check_int({tag, "_abort_valid"}, int'(ks_valid), 0);
                repeat (5) @(negedge clk);
                check_int({tag, "_abort_nodone"}, done_cnt - done0, 0);
                return;
            end
            if (ks_valid === 1'b1 && first < 0) first = cyc;
            if (reset_beat >= 0 && beats == reset_beat && ks_valid === 1'b1) begin
                reset_n = 1'b0;
                #1;
                check_int({tag, "_reset_outs"}, int'({ks_bit, ks_valid, busy, done}), 0);
                @(negedge clk);
                reset_n = 1'b1;
                check_int({tag, "_reset_nodone"}, done_cnt - done0, 0);
                return;
            end
            ks_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            start    = (mid_start && beats == 50) ? 1'b1 : 1'b0;
            if (ks_valid === 1'b1 && ks_ready) begin
                got[beats] = ks_bit;
                beats++;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        check_int({tag, "_beats"}, beats, 228);
        check_int({tag, "_latency"}, first, 188);
        check_int({tag, "_done_pulse"}, int'(done), 1);
        check_int({tag, "_valid_drop"}, int'(ks_valid), 0);
        check_int({tag, "_busy_drop"}, int'(busy), 0);
        if (done_start) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_int({tag, "_done_end"}, int'(done), 0);
        check_int({tag, "_idle_after"}, int'(busy), 0);
        check_int({tag, "_done_count"}, done_cnt - done0, 1);
    endtask

    initial begin
        logic [63:0] rk;
        logic [21:0] rf;
        ka = 120'h534EAA582FE8151AB6E1855A728C00;
        kb = 120'h24FD35A35D5FB6526D32F906DF1AC0;
        for (int i = 0; i < 114; i++) begin
            kat_exp[i]       = ka[119-i];
            kat_exp[114 + i] = kb[119-i];
        end

        repeat (3) @(negedge clk);
        check_int("reset_outputs", int'({ks_bit, ks_valid, busy, done}), 0);
        reset_n = 1'b1;

        build_ref(KAT_KEY, KAT_FRAME);
        check_vec("model_kat", model_bits, kat_exp);

        run_session(KAT_KEY, KAT_FRAME, 1'b0, 1'b0, 1'b0, -1, -1, "t1");
        check_vec("t1_stream", got, kat_exp);

        run_session(KAT_KEY, KAT_FRAME, 1'b1, 1'b0, 1'b0, -1, -1, "t2");
        check_vec("t2_stream", got, kat_exp);

        run_session(KAT_KEY, KAT_FRAME, 1'b0, 1'b1, 1'b1, -1, -1, "t3");
        check_vec("t3_stream", got, kat_exp);

        run_session(KAT_KEY, KAT_FRAME, 1'b0, 1'b0, 1'b0, 137, -1, "t4_abort");
        run_session(KAT_KEY, KAT_FRAME, 1'b0, 1'b0, 1'b0, -1, -1, "t4_rerun");
        check_vec("t4_stream", got, kat_exp);

        run_session(KAT_KEY, KAT_FRAME, 1'b0, 1'b0, 1'b0, -1, 40, "t5_reset");
        run_session(KAT_KEY, KAT_FRAME, 1'b0, 1'b0, 1'b0, -1, -1, "t5_rerun");
        check_vec("t5_stream", got, kat_exp);

        run_session(64'h0, 22'h0, 1'b1, 1'b0, 1'b0, -1, -1, "t6_zero");
        check_vec("t6_stream", got, '0);

        for (int i = 0; i < 3; i++) begin
            rk = {$urandom, $urandom};
            rf = 22'($urandom);
            build_ref(rk, rf);
            run_session(rk, rf, 1'b1, 1'b0, 1'b0, -1, -1, "rand");
            check_vec("rand_stream", got, model_bits);
        end

        check_int("stall_stable", stall_err, 0);
        check_int("majority_two", maj_err, 0);
        check_int("majority_seen", int'(maj_two > 0), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
